vec_serializer: RTL and testbench
=================================

Name: vec_serializer

Overview:
- Converts a stream of depth_p-lane vectors into a stream of single width_p lanes, one lane per beat, lane 0 first.
- Sits downstream of the vector pipeline registers and feeds scalar consumers such as an output writeback or a narrow bus.
- Both sides use a valid/ready handshake; a transfer occurs when valid and ready are both high on a rising clock edge.
- Sustains full throughput: back-to-back vectors produce depth_p consecutive output beats each, with no bubble between vectors.

Parameters:
width_p, 8, bit width of one lane
depth_p, 8, number of lanes per input vector (legal range ≥1)

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous, active-high reset
data_i  input  width_p x depth_p (unpacked array [depth_p-1:0])  input vector; lane k is data_i[k]
valid_i  input  1  input vector valid
ready_o  output  1  block can accept an input vector this cycle
valid_o  output  1  data_o holds a valid lane
data_o  output  width_p  current output lane
last_o  output  1  high when data_o is lane depth_p-1 of its vector
ready_i  input  1  downstream accepts data_o this cycle

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Storage:
  - Vector buffer buf[depth_p-1:0] holds the captured vector.
  - Lane index idx has width max(1,$clog2(depth_p)).
  - Status bit valid_o is registered.
- Reset (rst_i high at an edge):
  - valid_o=0, idx=0, buf all zero.
  - data_o=0 and last_o=0, because both are derived from the buffer and valid_o.
  - ready_o=1 in the first cycle after reset.
  - rst_i overrides any simultaneous handshake; a vector offered in the reset cycle is dropped.
- States:
  - EMPTY (valid_o=0).
  - BUSY (valid_o=1, idx = lane being presented).
- Outputs:
  - data_o = buf[idx] when valid_o=1, else 0.
  - last_o = valid_o & (idx==depth_p-1).
- ready_o = ~valid_o | (ready_i & last_o). This is a combinational path from ready_i; valid_i must not depend on ready_o.
- Input accept (valid_i & ready_o):
  - buf <= data_i, idx <= 0, valid_o <= 1.
  - First lane appears on data_o the next cycle, so input-to-first-output latency is 1 cycle.
- BUSY, ready_i=1, last_o=0: idx <= idx+1.
- BUSY, ready_i=1, last_o=1:
  - If valid_i=1, load the new vector (idx <= 0, valid_o stays 1) with no bubble.
  - Otherwise valid_o <= 0 and the block returns to EMPTY.
- BUSY, ready_i=0:
  - buf, idx and valid_o hold.
  - data_o and last_o remain stable.
  - ready_o=0.
- EMPTY, valid_i=0: no state change.
- depth_p=1:
  - idx is a constant 0 and last_o = valid_o.
  - Behaves as a single pipeline register with ready_o = ~valid_o | ready_i.
- Ordering:
  - Lanes leave in index order 0..depth_p-1.
  - Vectors leave in acceptance order; nothing is ever dropped or duplicated outside reset.
- Throughput: one lane per cycle when ready_i is held high and input is always valid.
- Reset mid-vector: partially sent vector is discarded; the next vector after reset starts at lane 0.

Test Plan:
1. Reset, then width_p=8, depth_p=4, present {lane0..3}={0x11,0x22,0x33,0x44} for one cycle with ready_i=1 -> ready_o=1 in the accept cycle; next 4 cycles data_o=0x11,0x22,0x33,0x44 with valid_o=1; last_o=1 only on 0x44; then valid_o=0.
2. Backpressure: same vector, ready_i low in cycles 2 and 3 of the burst -> data_o holds 0x22 while stalled; ready_o=0 throughout BUSY; the sequence still completes as 0x11,0x22,0x33,0x44 with no loss or repeat.
3. Back-to-back: valid_i held high with vector A={1,2,3,4} then B={5,6,7,8}, ready_i=1 -> 8 consecutive valid beats 1..8; ready_o=1 exactly in the cycle last_o=1 on lane 4; no idle cycle between 4 and 5.
4. Reset mid-operation: assert rst_i while data_o=0x22 -> next cycle valid_o=0, data_o=0, last_o=0, ready_o=1; a new vector {0xA0,0xA1,0xA2,0xA3} then emits starting at 0xA0.
5. depth_p=1, width_p=16: stream values 0x1234, 0x5678 with ready_i toggling 1,0,1 -> each value is emitted once with last_o=1; during the ready_i=0 cycle the output holds and ready_o=0.
6. Randomized valid_i/ready_i at 50% for 1000 vectors, depth_p=8 -> the scoreboard shows the output lane sequence equals the concatenated input vectors; last_o occurs every 8th beat; no handshake violations (data_o/valid_o stable while valid_o & ~ready_i).

Source files
------------

// File: rtl/vec_serializer.sv
`timescale 1ns/1ps
// vec_serializer
//   Accepts a depth_p-lane vector over a valid/ready handshake and replays it
//   as depth_p single-lane beats, lane 0 first. A new vector can be loaded in
//   the same cycle the last lane of the previous one is taken, so back-to-back
//   vectors stream without a bubble.
//
// Ports
//   clk_i    : clock, all state updates on the rising edge
//   rst_i    : synchronous active-high reset
//   data_i   : input vector, lane k is data_i[k]
//   valid_i  : input vector valid
//   ready_o  : block can accept an input vector this cycle
//   valid_o  : data_o holds a valid lane
//   data_o   : current output lane
//   last_o   : data_o is lane depth_p-1 of its vector
//   ready_i  : downstream accepts data_o this cycle
//
// state | meaning
// ------+----------------------------------------------------------
// EMPTY | no vector held, valid_o=0, ready for a new vector
// BUSY  | vector held, presenting lane idx_q on data_o

module vec_serializer #(
  parameter int width_p = 8,
  parameter int depth_p = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [width_p-1:0] data_i [depth_p-1:0],
  input  logic               valid_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  output logic               last_o,
  input  logic               ready_i
);

  localparam int idx_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(depth_p - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_e;

  state_e                state_q, state_n;
  logic [idx_w_lp-1:0]   idx_q, idx_n;
  logic                  load;
  logic [width_p-1:0]    vec_q [depth_p-1:0];

  assign valid_o = (state_q == BUSY);
  assign last_o  = valid_o & (idx_q == last_idx_lp);
  // Combinational from ready_i: the last lane leaving frees the buffer in
  // the same cycle, which is what keeps back-to-back vectors bubble-free.
  assign ready_o = ~valid_o | (ready_i & last_o);
  assign data_o  = valid_o ? vec_q[idx_q] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      for (int k = 0; k < depth_p; k++) begin
        vec_q[k] <= '0;
      end
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      if (load) begin
        vec_q <= data_i;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (valid_i) begin
          load    = 1'b1;
          idx_n   = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (ready_i) begin
          if (last_o) begin
            idx_n = '0;
            if (valid_i) begin
              load = 1'b1;
            end else begin
              state_n = EMPTY;
            end
          end else begin
            // Unreachable for depth_p=1 since last_o is always set in BUSY,
            // so idx stays at 0 there.
            idx_n = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_vec_serializer.sv
`timescale 1ns/1ps
module tb_vec_serializer;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst_i;

  // depth 4, width 8
  logic [7:0]  a_data [3:0];
  logic        a_valid_i, a_ready_o, a_valid_o, a_last_o, a_ready_i;
  logic [7:0]  a_data_o;
  // depth 1, width 16
  logic [15:0] b_data [0:0];
  logic        b_valid_i, b_ready_o, b_valid_o, b_last_o, b_ready_i;
  logic [15:0] b_data_o;
  // depth 8, width 8
  logic [7:0]  c_data [7:0];
  logic        c_valid_i, c_ready_o, c_valid_o, c_last_o, c_ready_i;
  logic [7:0]  c_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  vec_serializer #(.width_p(8), .depth_p(4)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(a_data), .valid_i(a_valid_i),
    .ready_o(a_ready_o), .valid_o(a_valid_o), .data_o(a_data_o),
    .last_o(a_last_o), .ready_i(a_ready_i));

  vec_serializer #(.width_p(16), .depth_p(1)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(b_data), .valid_i(b_valid_i),
    .ready_o(b_ready_o), .valid_o(b_valid_o), .data_o(b_data_o),
    .last_o(b_last_o), .ready_i(b_ready_i));

  vec_serializer #(.width_p(8), .depth_p(8)) u_c (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(c_data), .valid_i(c_valid_i),
    .ready_o(c_ready_o), .valid_o(c_valid_o), .data_o(c_data_o),
    .last_o(c_last_o), .ready_i(c_ready_i));

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load_a(input logic [7:0] l0, input logic [7:0] l1,
                        input logic [7:0] l2, input logic [7:0] l3);
    a_data[0] = l0;
    a_data[1] = l1;
    a_data[2] = l2;
    a_data[3] = l3;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    load_a(8'hde, 8'had, 8'hbe, 8'hef);
    a_valid_i = 1'b1; a_ready_i = 1'b1;
    b_data[0] = 16'hbeef; b_valid_i = 1'b1; b_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) c_data[k] = 8'(k + 1);
    c_valid_i = 1'b1; c_ready_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    a_valid_i = 1'b0; b_valid_i = 1'b0; c_valid_i = 1'b0;
    #1;
    n_checks++; if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid: got %b expected 0", a_valid_o); end
    n_checks++; if (a_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_a_data: got %h expected 00", a_data_o); end
    n_checks++; if (a_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_a_last: got %b expected 0", a_last_o); end
    n_checks++; if (a_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_a_ready: got %b expected 1", a_ready_o); end
    n_checks++; if (b_valid_o !== 1'b0 || b_data_o !== 16'h0 || b_last_o !== 1'b0 || b_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_b: got v=%b d=%h l=%b r=%b expected v=0 d=0000 l=0 r=1", b_valid_o, b_data_o, b_last_o, b_ready_o); end
    n_checks++; if (c_valid_o !== 1'b0 || c_data_o !== 8'h0 || c_last_o !== 1'b0 || c_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_c: got v=%b d=%h l=%b r=%b expected v=0 d=00 l=0 r=1", c_valid_o, c_data_o, c_last_o, c_ready_o); end
    step();
    n_checks++; if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got valid %b expected 0", a_valid_o); end
  endtask

  task automatic test_single();
    logic [7:0] exp_l [4];
    exp_l[0] = 8'h11; exp_l[1] = 8'h22; exp_l[2] = 8'h33; exp_l[3] = 8'h44;
    load_a(8'h11, 8'h22, 8'h33, 8'h44);
    a_valid_i = 1'b1; a_ready_i = 1'b1;
    #1;
    n_checks++; if (a_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_accept_ready: got %b expected 1", a_ready_o); end
    step();
    a_valid_i = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (a_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid[%0d]: got %b expected 1", k, a_valid_o); end
      n_checks++; if (a_data_o !== exp_l[k]) begin n_fail++; $display("FAIL single_data[%0d]: got %h expected %h", k, a_data_o, exp_l[k]); end
      n_checks++; if (a_last_o !== (k == 3)) begin n_fail++; $display("FAIL single_last[%0d]: got %b expected %b", k, a_last_o, (k == 3)); end
      step();
    end
    n_checks++; if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_idle: got valid %b expected 0", a_valid_o); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_l [4];
    bit         pat [6];
    int         k, cyc;
    exp_l[0] = 8'h11; exp_l[1] = 8'h22; exp_l[2] = 8'h33; exp_l[3] = 8'h44;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 1;
    load_a(8'h11, 8'h22, 8'h33, 8'h44);
    a_valid_i = 1'b1; a_ready_i = 1'b1;
    step();
    a_valid_i = 1'b0;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 20) begin
      a_ready_i = (cyc < 6) ? pat[cyc] : 1'b1;
      #1;
      n_checks++; if (a_valid_o !== 1'b1 || a_data_o !== exp_l[k] || a_last_o !== (k == 3)) begin
        n_fail++; $display("FAIL bp_beat[%0d]: got v=%b d=%h l=%b expected v=1 d=%h l=%b", cyc, a_valid_o, a_data_o, a_last_o, exp_l[k], (k == 3)); end
      n_checks++; if (a_ready_o !== (a_ready_i && k == 3)) begin
        n_fail++; $display("FAIL bp_ready[%0d]: got %b expected %b", cyc, a_ready_o, (a_ready_i && k == 3)); end
      if (a_ready_i) k++;
      cyc++;
      step();
    end
    n_checks++; if (k != 4) begin n_fail++; $display("FAIL bp_timeout: got %0d lanes expected 4", k); end
    n_checks++; if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got valid %b expected 0", a_valid_o); end
    a_ready_i = 1'b1;
  endtask

  task automatic test_back_to_back();
    load_a(8'd1, 8'd2, 8'd3, 8'd4);
    a_valid_i = 1'b1; a_ready_i = 1'b1;
    step();
    load_a(8'd5, 8'd6, 8'd7, 8'd8);
    for (int b = 1; b <= 8; b++) begin
      if (b == 5) a_valid_i = 1'b0;
      #1;
      n_checks++; if (a_valid_o !== 1'b1 || a_data_o !== 8'(b)) begin
        n_fail++; $display("FAIL b2b_beat[%0d]: got v=%b d=%0d expected v=1 d=%0d", b, a_valid_o, a_data_o, b); end
      n_checks++; if (a_last_o !== (b % 4 == 0) || a_ready_o !== (b % 4 == 0)) begin
        n_fail++; $display("FAIL b2b_last_ready[%0d]: got l=%b r=%b expected %b", b, a_last_o, a_ready_o, (b % 4 == 0)); end
      step();
    end
    n_checks++; if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got valid %b expected 0", a_valid_o); end
  endtask

  task automatic test_reset_mid();
    load_a(8'h11, 8'h22, 8'h33, 8'h44);
    a_valid_i = 1'b1; a_ready_i = 1'b1;
    step();
    a_valid_i = 1'b0;
    step();
    n_checks++; if (a_data_o !== 8'h22) begin n_fail++; $display("FAIL rmid_pre: got %h expected 22", a_data_o); end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    n_checks++; if (a_valid_o !== 1'b0 || a_data_o !== 8'h00 || a_last_o !== 1'b0 || a_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL rmid_post: got v=%b d=%h l=%b r=%b expected v=0 d=00 l=0 r=1", a_valid_o, a_data_o, a_last_o, a_ready_o); end
    load_a(8'ha0, 8'ha1, 8'ha2, 8'ha3);
    a_valid_i = 1'b1;
    step();
    a_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (a_valid_o !== 1'b1 || a_data_o !== 8'(8'ha0 + k)) begin
        n_fail++; $display("FAIL rmid_lane[%0d]: got v=%b d=%h expected v=1 d=%h", k, a_valid_o, a_data_o, 8'(8'ha0 + k)); end
      step();
    end
  endtask

  task automatic test_depth1();
    b_ready_i = 1'b1;
    b_data[0] = 16'h1234; b_valid_i = 1'b1;
    #1;
    n_checks++; if (b_ready_o !== 1'b1) begin n_fail++; $display("FAIL d1_accept: got ready %b expected 1", b_ready_o); end
    step();
    b_data[0] = 16'h5678;
    #1;
    n_checks++; if (b_valid_o !== 1'b1 || b_data_o !== 16'h1234 || b_last_o !== 1'b1 || b_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL d1_beat0: got v=%b d=%h l=%b r=%b expected v=1 d=1234 l=1 r=1", b_valid_o, b_data_o, b_last_o, b_ready_o); end
    step();
    b_valid_i = 1'b0; b_ready_i = 1'b0;
    #1;
    n_checks++; if (b_valid_o !== 1'b1 || b_data_o !== 16'h5678 || b_last_o !== 1'b1 || b_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL d1_stall: got v=%b d=%h l=%b r=%b expected v=1 d=5678 l=1 r=0", b_valid_o, b_data_o, b_last_o, b_ready_o); end
    step();
    b_ready_i = 1'b1;
    #1;
    n_checks++; if (b_valid_o !== 1'b1 || b_data_o !== 16'h5678 || b_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL d1_beat1: got v=%b d=%h r=%b expected v=1 d=5678 r=1", b_valid_o, b_data_o, b_ready_o); end
    step();
    n_checks++; if (b_valid_o !== 1'b0) begin n_fail++; $display("FAIL d1_idle: got valid %b expected 0", b_valid_o); end
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic [7:0] exp_d, prev_data;
    logic       prev_last;
    bit         pend, stalled_prev;
    int         accepted, beats, cyc;
    accepted = 0; beats = 0; cyc = 0; pend = 0; stalled_prev = 0;
    prev_data = '0; prev_last = 1'b0;
    while ((accepted < 1000 || q.size() != 0) && cyc < 30000) begin
      if (!pend) begin
        c_valid_i = (accepted < 1000) && ($urandom_range(1, 0) == 1);
        for (int k = 0; k < 8; k++) c_data[k] = 8'($urandom);
      end
      c_ready_i = ($urandom_range(1, 0) == 1);
      #1;
      if (stalled_prev) begin
        n_checks++; if (c_valid_o !== 1'b1 || c_data_o !== prev_data || c_last_o !== prev_last) begin
          n_fail++; $display("FAIL rnd_stable[%0d]: got v=%b d=%h l=%b expected v=1 d=%h l=%b", cyc, c_valid_o, c_data_o, c_last_o, prev_data, prev_last); end
      end
      n_checks++; if (c_valid_o !== (q.size() != 0)) begin
        n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", cyc, c_valid_o, (q.size() != 0)); end
      if (c_valid_o === 1'b1 && c_ready_i) begin
        if (q.size() != 0) begin
          exp_d = q.pop_front();
          n_checks++; if (c_data_o !== exp_d) begin
            n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", beats, c_data_o, exp_d); end
          n_checks++; if (c_last_o !== (beats % 8 == 7)) begin
            n_fail++; $display("FAIL rnd_last[%0d]: got %b expected %b", beats, c_last_o, (beats % 8 == 7)); end
          beats++;
        end
      end
      n_checks++; if (c_ready_o !== (q.size() == 0)) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", cyc, c_ready_o, (q.size() == 0)); end
      if (c_valid_i && c_ready_o === 1'b1) begin
        for (int k = 0; k < 8; k++) q.push_back(c_data[k]);
        accepted++;
        pend = 0;
      end else begin
        pend = c_valid_i;
      end
      stalled_prev = (c_valid_o === 1'b1) && !c_ready_i;
      prev_data = c_data_o;
      prev_last = c_last_o;
      cyc++;
      step();
    end
    n_checks++; if (accepted != 1000 || q.size() != 0 || beats != 8000) begin
      n_fail++; $display("FAIL rnd_timeout: got accepted=%0d pending=%0d beats=%0d expected 1000/0/8000", accepted, q.size(), beats); end
    c_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    a_valid_i = 1'b0; a_ready_i = 1'b0;
    b_valid_i = 1'b0; b_ready_i = 1'b0;
    c_valid_i = 1'b0; c_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) a_data[k] = '0;
    b_data[0] = '0;
    for (int k = 0; k < 8; k++) c_data[k] = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_depth1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
